// File: rtl/stump_mem_if_pkg.sv
// stump_mem_if_pkg: shared definitions for the Stump memory bus interface.
//   mif_state_t : bus FSM states (IDLE, REQ, DONE), 2-bit encoding
//   acc_kind_t  : kind of access held for the transaction in flight
//   sel_kind()  : strobe priority, write > read > fetch
//   is_conflict(): more than one strobe asserted in the same cycle
package stump_mem_if_pkg;

    typedef enum logic [1:0] {
        MIF_IDLE = 2'd0,
        MIF_REQ  = 2'd1,
        MIF_DONE = 2'd2
    } mif_state_t;

    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_kind_t;

    function automatic acc_kind_t sel_kind(input logic mem_ren, input logic mem_wen);
        if (mem_wen)
            return ACC_STORE;
        else if (mem_ren)
            return ACC_LOAD;
        else
            return ACC_FETCH;
    endfunction

    function automatic logic is_conflict(input logic fetch, input logic mem_ren,
                                         input logic mem_wen);
        return (fetch & mem_ren) | (fetch & mem_wen) | (mem_ren & mem_wen);
    endfunction

endpackage

// File: rtl/stump_mem_if_if.sv
// stump_mem_if_if: external memory bus between the Stump core and memory.
//   ext_req   : bus request (core -> memory)
//   ext_we    : write enable, valid while ext_req is high
//   ext_addr  : address, valid while ext_req is high
//   ext_wdata : write data, valid while ext_req is high
//   ext_ack   : completion; read data valid in the same cycle (memory -> core)
//   ext_rdata : read data (memory -> core)
// Modports: master (core side), slave (memory side).
interface stump_mem_if_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ack;
    logic [DATA_W-1:0] ext_rdata;

    modport master (
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata
    );

    modport slave (
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ack, ext_rdata
    );
endinterface

// File: rtl/stump_mem_if_timer.sv
// stump_mem_timer: saturating cycle counter used as the bus timeout.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count at zero (takes priority over en)
//   en       : count this cycle
//   expired  : the current cycle is the TIMEOUT-th counted cycle or later
module stump_mem_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && cnt != LIMIT)
            cnt <= cnt + CW'(1);
    end

    // cnt counts completed cycles, so the TIMEOUT-th cycle sees cnt == TIMEOUT-1
    assign expired = en && (cnt >= LAST);
endmodule

// File: rtl/stump_mem_if.sv
// stump_mem_if: turns the Stump control unit's fetch/load/store strobes into
// req/ack transactions on the external memory bus.
//   clk, rst       : clock, synchronous active-high reset
//   fetch          : instruction fetch at addr
//   mem_ren        : data load at addr
//   mem_wen        : data store of wdata at addr
//   addr, wdata    : access address and store data
//   ir             : instruction register, written when a fetch completes
//   rdata          : load data register, written when a load completes
//   rdata_valid    : one-cycle pulse in DONE of a load
//   stall          : core must hold state this cycle
//   bus_err        : sticky timeout / conflicting-strobe flag
//   bus            : external memory bus (master side)
module stump_mem_if
    import stump_mem_if_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              bus_err,
    stump_mem_if_if.master    bus
);
    mif_state_t        state, state_nxt;
    acc_kind_t         kind;
    logic              pend;
    logic              expired;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign pend = fetch | mem_ren | mem_wen;

    stump_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == MIF_IDLE && pend),
        .en      (state == MIF_REQ),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= MIF_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MIF_IDLE: if (pend) state_nxt = MIF_REQ;
            MIF_REQ:  if (bus.ext_ack || expired) state_nxt = MIF_DONE;
            MIF_DONE: state_nxt = MIF_IDLE;
            default:  state_nxt = MIF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kind    <= ACC_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ir      <= '0;
            rdata   <= '0;
            bus_err <= 1'b0;
        end else begin
            case (state)
                MIF_IDLE: begin
                    if (pend) begin
                        kind    <= sel_kind(mem_ren, mem_wen);
                        we_q    <= mem_wen;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (is_conflict(fetch, mem_ren, mem_wen))
                            bus_err <= 1'b1;
                    end
                end
                MIF_REQ: begin
                    // An ack in the last allowed cycle still wins over the timeout
                    if (bus.ext_ack) begin
                        if (kind == ACC_FETCH) ir    <= bus.ext_rdata;
                        if (kind == ACC_LOAD)  rdata <= bus.ext_rdata;
                    end else if (expired) begin
                        bus_err <= 1'b1;
                        if (kind == ACC_FETCH) ir    <= '0;
                        if (kind == ACC_LOAD)  rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ext_req   = (state == MIF_REQ);
    assign bus.ext_we    = we_q;
    assign bus.ext_addr  = addr_q;
    assign bus.ext_wdata = wdata_q;

    assign stall       = pend && (state != MIF_DONE);
    assign rdata_valid = (state == MIF_DONE) && (kind == ACC_LOAD);
endmodule

// File: tb/tb_stump_mem_if.sv
// tb_stump_mem_if: directed bench for stump_mem_if with TIMEOUT = 4.
// Each access is described at transaction level (strobes, wait states, read
// value); the bench expands it into the per-cycle expected outputs and a
// compare process checks every cycle against that expectation.
module tb_stump_mem_if;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch, mem_ren, mem_wen;
    logic [15:0] addr, wdata;
    logic [15:0] ir, rdata;
    logic        rdata_valid, stall, bus_err;

    stump_mem_if_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    stump_mem_if #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch       (fetch),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .addr        (addr),
        .wdata       (wdata),
        .ir          (ir),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .bus_err     (bus_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        stall;
        logic        rv;
        logic [15:0] ir;
        logic [15:0] rdata;
        logic        err;
    } row_t;

    row_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // model architectural state
    logic [15:0] m_ir = '0, m_rdata = '0;
    logic        m_err = 1'b0;

    // per-access observation counters (cleared by the driver)
    int stall_cnt, req_cnt, rv_cnt, we_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process
    initial begin
        forever begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (bus.ext_req) req_cnt++;
            if (rdata_valid) rv_cnt++;
            if (bus.ext_req && bus.ext_we) we_seen++;
            if (q.size() > 0) begin
                row_t r;
                r = q.pop_front();
                chk("ext_req", {31'b0, bus.ext_req}, {31'b0, r.req});
                chk("stall", {31'b0, stall}, {31'b0, r.stall});
                chk("rdata_valid", {31'b0, rdata_valid}, {31'b0, r.rv});
                chk("ir", {16'b0, ir}, {16'b0, r.ir});
                chk("rdata", {16'b0, rdata}, {16'b0, r.rdata});
                chk("bus_err", {31'b0, bus_err}, {31'b0, r.err});
                if (r.req) begin
                    chk("ext_we", {31'b0, bus.ext_we}, {31'b0, r.we});
                    chk("ext_addr", {16'b0, bus.ext_addr}, {16'b0, r.addr});
                    chk("ext_wdata", {16'b0, bus.ext_wdata}, {16'b0, r.wdata});
                end
            end
        end
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic req, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, input logic st, input logic rv);
        row_t r;
        r.req = req; r.we = we; r.addr = a; r.wdata = wd;
        r.stall = st; r.rv = rv;
        r.ir = m_ir; r.rdata = m_rdata; r.err = m_err;
        q.push_back(r);
    endtask

    task automatic clear_counts();
        stall_cnt = 0; req_cnt = 0; rv_cnt = 0; we_seen = 0;
    endtask

    // waits < 0 : memory never acks
    task automatic access(input logic f, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] wd,
                          input int waits, input logic [15:0] rd);
        int  nreq;
        bit  timed;
        bit  is_load, is_fetch;
        timed    = (waits < 0);
        nreq     = timed ? TO : waits + 1;
        is_load  = !w && r;
        is_fetch = !w && !r;
        clear_counts();
        fetch = f; mem_ren = r; mem_wen = w; addr = a; wdata = wd;
        bus.ext_ack = 1'b0; bus.ext_rdata = rd;
        push(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        advance();
        if (int'(f) + int'(r) + int'(w) > 1) m_err = 1'b1;
        for (int c = 1; c <= nreq; c++) begin
            bus.ext_ack = !timed && (c == nreq);
            push(1'b1, w, a, wd, 1'b1, 1'b0);
            advance();
        end
        if (timed) begin
            m_err = 1'b1;
            if (is_fetch) m_ir = 16'h0000;
            if (is_load)  m_rdata = 16'h0000;
        end else begin
            if (is_fetch) m_ir = rd;
            if (is_load)  m_rdata = rd;
        end
        // ack outside REQ must be ignored
        bus.ext_ack = 1'b1; bus.ext_rdata = 16'hDEAD;
        push(1'b0, 1'b0, '0, '0, 1'b0, is_load);
        advance();
        fetch = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        push(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        advance();
        bus.ext_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetch = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        addr = '0; wdata = '0; bus.ext_ack = 1'b0; bus.ext_rdata = '0;
        clear_counts();
        advance();
        advance();
        rst = 1'b0;
        chk("rst_ir", {16'b0, ir}, 32'h0);
        chk("rst_rdata", {16'b0, rdata}, 32'h0);
        chk("rst_ext_addr", {16'b0, bus.ext_addr}, 32'h0);
        chk("rst_ext_wdata", {16'b0, bus.ext_wdata}, 32'h0);
        chk("rst_flags", {27'b0, bus.ext_req, bus.ext_we, rdata_valid, bus_err, stall}, 32'h0);
        push(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        advance();

        // zero-wait fetch
        access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 16'hA5C3);
        chk("fetch_ir_lit", {16'b0, ir}, 32'hA5C3);
        chk("fetch_stall_cycles", stall_cnt, 2);
        chk("fetch_req_cycles", req_cnt, 1);

        // load with 3 wait states (ack lands in the last cycle before timeout)
        access(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 3, 16'h1234);
        chk("load_rdata_lit", {16'b0, rdata}, 32'h1234);
        chk("load_stall_cycles", stall_cnt, 5);
        chk("load_rv_pulses", rv_cnt, 1);
        chk("load_ir_kept", {16'b0, ir}, 32'hA5C3);
        chk("load_no_we", we_seen, 0);

        // store, immediate ack
        access(1'b0, 1'b0, 1'b1, 16'hFFFE, 16'hBEEF, 0, 16'h5555);
        chk("store_no_rv", rv_cnt, 0);
        chk("store_we_seen", we_seen, 1);
        chk("store_rdata_kept", {16'b0, rdata}, 32'h1234);
        chk("store_err_clear", {31'b0, bus_err}, 32'h0);

        // fetch that is never acked
        access(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, -1, 16'h7777);
        chk("timeout_ir_lit", {16'b0, ir}, 32'h0);
        chk("timeout_req_cycles", req_cnt, TO);
        chk("timeout_err_lit", {31'b0, bus_err}, 32'h1);

        // good load afterwards; error stays sticky
        access(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0000, 1, 16'hCAFE);
        chk("sticky_err", {31'b0, bus_err}, 32'h1);
        chk("load2_rdata_lit", {16'b0, rdata}, 32'hCAFE);

        // reset while waiting in REQ, then a late ack
        clear_counts();
        fetch = 1'b1; addr = 16'h0500; bus.ext_rdata = 16'hFFFF;
        push(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        advance();
        push(1'b1, 1'b0, 16'h0500, 16'h0000, 1'b1, 1'b0);
        advance();
        rst = 1'b1;
        push(1'b1, 1'b0, 16'h0500, 16'h0000, 1'b1, 1'b0);
        advance();
        rst = 1'b0; fetch = 1'b0; bus.ext_ack = 1'b1;
        m_ir = '0; m_rdata = '0; m_err = 1'b0;
        push(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("rst_mid_ext_addr", {16'b0, bus.ext_addr}, 32'h0);
        chk("rst_mid_ext_req", {31'b0, bus.ext_req}, 32'h0);
        advance();
        bus.ext_ack = 1'b0;
        push(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        advance();
        chk("rst_mid_ir", {16'b0, ir}, 32'h0);
        chk("rst_mid_err", {31'b0, bus_err}, 32'h0);

        // conflicting strobes: write wins, error flagged
        access(1'b0, 1'b1, 1'b1, 16'h0123, 16'h0F0F, 0, 16'h9999);
        chk("conflict_we_seen", we_seen, 1);
        chk("conflict_err_lit", {31'b0, bus_err}, 32'h1);
        chk("conflict_rdata_kept", {16'b0, rdata}, 32'h0);
        chk("conflict_no_rv", rv_cnt, 0);

        advance();
        advance();
        if (q.size() != 0) chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
